// File: rtl/adder64_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder64_seq_ctrl: WIDTH-bit add sequenced over an external SLICE-bit      |
// | adder, LS slice first, carry chained through a register.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module adder64_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [SLICE-1:0] sl_A,
  output logic [SLICE-1:0] sl_B,
  output logic             sl_Cin,
  input  logic [SLICE-1:0] sl_S,
  input  logic             sl_Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int BEATS = WIDTH / SLICE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("adder64_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [31:0]      base;

  assign base      = 32'(beat_q) * SLICE;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sl_A    = '0;
    sl_B    = '0;
    sl_Cin  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sl_A   = a_q[base +: SLICE];
        sl_B   = b_q[base +: SLICE];
        sl_Cin = carry_q;
        s_d[base +: SLICE] = sl_S;
        carry_d = sl_Cout;
        if (beat_q == BW'(BEATS - 1)) begin
          cout_d  = sl_Cout;
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; result registers keep their old contents.
    if (flush) begin
      state_d = IDLE;
      beat_d  = '0;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder64_seq_ctrl.sv
`default_nettype none
// Bench for adder64_seq_ctrl: external 16-bit slice adder, arithmetic model, directed vectors.
module tb_adder64_seq_ctrl;
  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int BEATS = WIDTH / SLICE;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, Cin = 1'b0;
  logic [63:0] A = '0, B = '0;
  wire  logic in_ready, out_valid, Cout, sl_Cin, sl_Cout;
  wire  logic [15:0] sl_A, sl_B, sl_S;
  wire  logic [63:0] S;

  // external adder slice
  assign {sl_Cout, sl_S} = {1'b0, sl_A} + {1'b0, sl_B} + {16'b0, sl_Cin};

  adder64_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sl_A(sl_A), .sl_B(sl_B), .sl_Cin(sl_Cin),
    .sl_S(sl_S), .sl_Cout(sl_Cout), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int acc_cyc[$];
  logic [64:0] res_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted pair yields A+B+Cin exactly BEATS edges later; held until taken.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_a = '0, m_b = '0, m_S = '0;
  logic        m_cin = 1'b0, m_Cout = 1'b0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_S = '0; m_Cout = 1'b0;
      m_a = '0; m_b = '0; m_cin = 1'b0;
    end else if (flush) begin
      m_left = 0; m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        {m_Cout, m_S} = m_pend;
      end
    end else if (in_valid) begin
      m_a = A; m_b = B; m_cin = Cin;
      m_pend = {1'b0, A} + {1'b0, B} + {64'b0, Cin};
      m_left = BEATS;
    end
  end

  always @(negedge clk) begin : cmp
    int b;
    logic [64:0] mask, part;
    chk("in_ready", {64'b0, in_ready}, {64'b0, (!m_done && m_left == 0)});
    chk("out_valid", {64'b0, out_valid}, {64'b0, m_done});
    if (m_left > 0) begin
      b    = BEATS - m_left;
      mask = (65'd1 << (b * SLICE)) - 65'd1;
      part = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + {64'b0, m_cin};
      chk("sl_A", {49'b0, sl_A}, {49'b0, m_a[b*SLICE +: SLICE]});
      chk("sl_B", {49'b0, sl_B}, {49'b0, m_b[b*SLICE +: SLICE]});
      chk("sl_Cin", {64'b0, sl_Cin}, {64'b0, part[b*SLICE]});
    end else begin
      chk("sl_idle", {32'b0, sl_A, sl_B, sl_Cin}, 65'b0);
    end
    if (m_done) chk("result", {Cout, S}, {m_Cout, m_S});
    if (out_valid && out_ready) res_q.push_back({Cout, S});
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input bit hold);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; A = a; B = b; Cin = c;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc.push_back(cyc);
        got = 1'b1;
      end
    end
    if (!got) chk("accept_timeout", 65'd0, 65'd1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) chk("result_timeout", 65'd0, 65'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_S", {Cout, S}, 65'd0);
    chk("rst_out_valid", {64'b0, out_valid}, 65'd0);
    chk("rst_sl", {32'b0, sl_A, sl_B, sl_Cin}, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {64'b0, in_ready}, 65'd1);
    @(posedge clk); #1;

    // basic add and latency
    send(64'h1, 64'h2, 1'b0, 1'b0);
    wait_out(n);
    chk("basic_latency", 65'(n), 65'd5);
    chk("basic_sum", {Cout, S}, 65'h0_0000_0000_0000_0003);
    @(posedge clk); #1;

    // full carry ripple
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < BEATS; i++) begin
      @(negedge clk);
      chk("ripple_sl_Cin", {64'b0, sl_Cin}, 65'd1);
    end
    wait_out(n);
    chk("ripple_sum", {Cout, S}, 65'h1_0000_0000_0000_0000);
    @(posedge clk); #1;

    // backpressure
    out_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {Cout, S}, 65'h0_1234_5678_9ABC_DF00);
      chk("bp_in_ready", {64'b0, in_ready}, 65'd0);
      chk("bp_out_valid", {64'b0, out_valid}, 65'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {63'b0, in_ready, out_valid}, 65'd2);
    @(posedge clk); #1;

    // back-to-back with in_valid held high
    res_q.delete();
    acc_cyc.delete();
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_out(n);
    @(posedge clk); #1;
    chk("b2b_count", 65'(res_q.size()), 65'd3);
    if (res_q.size() == 3) begin
      chk("b2b_r0", res_q[0], 65'h1_0000_0000_0000_0000);
      chk("b2b_r1", res_q[1], 65'h0_0000_0000_0001_0000);
      chk("b2b_r2", res_q[2], 65'h1_FFFF_FFFF_FFFF_FFFF);
    end
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 65'(acc_cyc[1] - acc_cyc[0]), 65'd6);
      chk("b2b_gap1", 65'(acc_cyc[2] - acc_cyc[1]), 65'd6);
    end else chk("b2b_accepts", 65'(acc_cyc.size()), 65'd3);

    // flush during beat 2
    send(64'h0000_1111_2222_3333, 64'h0000_0001_0001_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {64'b0, in_ready}, 65'd1);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", {64'b0, out_valid}, 65'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(64'd5, 64'd7, 1'b0, 1'b0);
    wait_out(n);
    chk("post_flush_sum", {Cout, S}, 65'd12);
    @(posedge clk); #1;

    // async reset between edges mid-RUN
    send(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {63'b0, out_valid, Cout}, 65'd0);
    chk("arst_S", {1'b0, S}, 65'd0);
    chk("arst_sl", {32'b0, sl_A, sl_B, sl_Cin}, 65'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {63'b0, in_ready, out_valid}, 65'd2);
    @(posedge clk); #1;
    send(64'd3, 64'd4, 1'b1, 1'b0);
    wait_out(n);
    chk("final_sum", {Cout, S}, 65'd8);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adder64_seq_ctrl.md
Name: adder64_seq_ctrl

Overview:
- Sequencer that computes a WIDTH-bit sum by driving one external SLICE-bit ripple adder slice (adder16-class) over WIDTH/SLICE consecutive beats, least-significant slice first, with carry chained through a register.
- Serves area-constrained multiplier datapaths: accepts one operand pair via valid/ready, returns the registered sum and carry-out via valid/ready.

Parameters:
- WIDTH, 64, total operand/sum width; must be an integer multiple of SLICE.
- SLICE, 16, width of the external adder slice.
- BEATS (localparam), WIDTH/SLICE, number of slice additions per operation (4 at defaults).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns block to IDLE
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in to the least-significant slice
- sl_A  output  SLICE  operand A slice to external adder
- sl_B  output  SLICE  operand B slice to external adder
- sl_Cin  output  1  carry into external adder
- sl_S  input  SLICE  sum from external adder (combinational)
- sl_Cout  input  1  carry-out from external adder
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  registered sum
- Cout  output  1  registered final carry-out

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, beat counter 0, operand/sum/carry registers 0; in_ready=1 as soon as rst_n is high again, out_valid=0, S=0, Cout=0, sl_A=0, sl_B=0, sl_Cin=0.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready at edge k: latch A, B into operand registers, carry register <= Cin, beat <= 0, go RUN.
- RUN: sl_A = A_r[beat*SLICE +: SLICE], sl_B = B_r[same slice], sl_Cin = carry register. At each edge: S_r[beat slice] <= sl_S, carry <= sl_Cout, beat++. After capturing beat BEATS-1: Cout <= sl_Cout, go DONE.
- Outside RUN, sl_A, sl_B and sl_Cin are driven 0.
- Latency: out_valid rises after edge k+BEATS (k+4 at defaults). Throughput: one operation per BEATS+2 cycles when out_ready is held high.
- DONE: S and Cout are held stable while out_valid=1. On out_ready high, go IDLE at that edge; in_ready is high in the following cycle. No accept/complete overlap, no bypass.
- S holds its last result in IDLE and RUN until overwritten slice-by-slice. Consumers sample S only while out_valid=1.
- flush: highest priority over all handshakes. At the edge it is sampled high: state <= IDLE, beat <= 0, out_valid drops; S and Cout are not cleared. An in_valid in the same cycle is ignored.
- Reset mid-RUN or in DONE: immediate return to the reset values above; any partial result is discarded.
- Arithmetic is modulo 2^WIDTH; overflow is reported only through Cout. Carry propagates strictly slice to slice.
- Beat counter width is clog2(BEATS) bits, minimum 1. The counter never wraps inside RUN.
- Elaboration fails if WIDTH % SLICE != 0.

Test Plan:
- Basic add: bench models sl_S/sl_Cout as a 16-bit adder. A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0002, Cin=0 -> out_valid after 4 RUN cycles, S=0x3, Cout=0.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> sl_Cin is 1,1,1,1 across the beats; S=0, Cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> S and Cout held stable, in_ready=0 throughout; IDLE reached the cycle after out_ready=1.
- Back-to-back: in_valid held high with 3 operand pairs and out_ready=1 -> each result is correct (e.g. 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> S=0, Cout=1), with a 6-cycle accept spacing.
- Flush at beat 2 -> state IDLE at the next edge, out_valid never rises; the next operation (A=5, B=7) gives S=12.
- Async reset asserted mid-RUN, between clock edges -> outputs zero immediately without a clock edge; in_ready=1 once rst_n is released.
